// File: rtl/block_buffer.sv
// Small FIFO between the 128-bit block assembler and the cipher core.
// Blocks arrive over a 4-phase data_ready/data_taken handshake and leave over valid/ready.
module block_buffer #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_data_ready,
    input  logic [DATA_W-1:0]        i_block_in,
    output logic                     o_data_taken,
    output logic                     o_blk_valid,
    output logic [DATA_W-1:0]        o_blk_data,
    input  logic                     i_blk_ready,
    output logic [$clog2(DEPTH):0]   o_blk_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {
        ST_IDLE,
        ST_ACK
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     w_count;
    logic              r_data_taken;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    // Pointers carry an extra MSB, so their difference is the true occupancy 0..DEPTH.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == PW'(DEPTH));
    assign w_empty = (w_count == '0);
    assign w_pop   = !w_empty && i_blk_ready;

    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_data_ready && !w_full) begin
                    w_push       = 1'b1;
                    w_next_state = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!i_data_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Storage is cleared on reset so the head output reads zero afterwards.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_data_taken <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state      <= w_next_state;
            r_data_taken <= (w_next_state == ST_ACK);
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_block_in;
                r_wr_ptr                <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    assign o_data_taken = r_data_taken;
    assign o_blk_valid  = !w_empty;
    assign o_blk_data   = r_mem[r_rd_ptr[AW-1:0]];
    assign o_blk_count  = w_count;

endmodule

// File: tb/tb_block_buffer.sv
// Bench for block_buffer: queue-based reference model checked every cycle,
// directed handshake scenarios with literal expectations, then randomized traffic.
module tb_block_buffer;

    localparam int DATA_W = 128;
    localparam int DEPTH  = 2;

    logic              clk;
    logic              rst;
    logic              dataReady;
    logic [DATA_W-1:0] blockIn;
    logic              dataTaken;
    logic              blkValid;
    logic [DATA_W-1:0] blkData;
    logic              blkReady;
    logic [1:0]        blkCount;

    int numChecks = 0;
    int numFails  = 0;

    logic [DATA_W-1:0] mQ [$];
    logic              mAck    = 1'b0;
    logic              mTaken  = 1'b0;
    logic              mInit   = 1'b0;
    logic              streamMode = 1'b0;

    localparam logic [DATA_W-1:0] BLK_X = 128'h1234567890abcdef1234567890abcdef;
    localparam logic [DATA_W-1:0] BLK_A = 128'habc10000_11112222_33334444_5555abc1;
    localparam logic [DATA_W-1:0] BLK_B = 128'h47290000_66667777_88889999_aaaa4729;
    localparam logic [DATA_W-1:0] BLK_C = 128'h19350000_bbbbcccc_ddddeeee_ffff1935;

    block_buffer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data_ready(dataReady),
        .i_block_in  (blockIn),
        .o_data_taken(dataTaken),
        .o_blk_valid (blkValid),
        .o_blk_data  (blkData),
        .i_blk_ready (blkReady),
        .o_blk_count (blkCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                               input logic [DATA_W-1:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic dr, input logic [DATA_W-1:0] blk, input logic br);
        dataReady = dr;
        blockIn   = blk;
        blkReady  = br;
    endtask

    task automatic waitTakenLevel(input logic lvl, input string name);
        int n = 0;
        while (dataTaken !== lvl && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {127'd0, dataTaken}, {127'd0, lvl});
    endtask

    task automatic deliver(input logic [DATA_W-1:0] blk);
        applyStimulus(1'b1, blk, blkReady);
        waitTakenLevel(1'b1, "deliver_taken_rise");
        applyStimulus(1'b0, blk, blkReady);
        waitTakenLevel(1'b0, "deliver_taken_fall");
    endtask

    // Reference: a bounded queue plus one "acknowledged, waiting for data_ready low" flag.
    always @(posedge clk) begin
        if (rst) begin
            mQ.delete();
            mAck   = 1'b0;
            mTaken = 1'b0;
            mInit  = 1'b1;
        end else if (mInit) begin
            logic doPop;
            logic doPush;
            doPop  = (mQ.size() != 0) && blkReady;
            doPush = !mAck && dataReady && (mQ.size() < DEPTH);
            if (doPop)  void'(mQ.pop_front());
            if (doPush) mQ.push_back(blockIn);
            if (mAck && !dataReady) mAck = 1'b0;
            else if (doPush)        mAck = 1'b1;
            mTaken = mAck;
        end
    end

    always @(negedge clk) begin
        if (mInit) begin
            checkOutput("model_taken", {127'd0, dataTaken}, {127'd0, mTaken});
            checkOutput("model_valid", {127'd0, blkValid}, {127'd0, (mQ.size() != 0)});
            checkOutput("model_count", {126'd0, blkCount}, DATA_W'(mQ.size()));
            if (mQ.size() != 0) checkOutput("model_data", blkData, mQ[0]);
            if (streamMode) checkOutput("stream_count_le1", {127'd0, (blkCount <= 2'd1)}, 128'd1);
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);

        // Reset
        repeat (2) @(negedge clk);
        checkOutput("reset_taken", {127'd0, dataTaken}, 128'd0);
        checkOutput("reset_valid", {127'd0, blkValid}, 128'd0);
        checkOutput("reset_count", {126'd0, blkCount}, 128'd0);
        checkOutput("reset_data", blkData, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single block, then hold data_ready high
        applyStimulus(1'b1, BLK_X, 1'b0);
        @(negedge clk);
        checkOutput("single_taken", {127'd0, dataTaken}, 128'd1);
        checkOutput("single_valid", {127'd0, blkValid}, 128'd1);
        checkOutput("single_data", blkData, BLK_X);
        checkOutput("single_count", {126'd0, blkCount}, 128'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold_count", {126'd0, blkCount}, 128'd1);
            checkOutput("hold_taken", {127'd0, dataTaken}, 128'd1);
        end
        applyStimulus(1'b0, BLK_X, 1'b0);
        @(negedge clk);
        checkOutput("release_taken", {127'd0, dataTaken}, 128'd0);
        checkOutput("release_count", {126'd0, blkCount}, 128'd1);
        applyStimulus(1'b0, BLK_X, 1'b1);
        @(negedge clk);
        checkOutput("drain_count", {126'd0, blkCount}, 128'd0);
        applyStimulus(1'b0, BLK_X, 1'b0);
        @(negedge clk);

        // Full FIFO withholds the acknowledge
        deliver(BLK_A);
        deliver(BLK_B);
        checkOutput("full_count", {126'd0, blkCount}, 128'd2);
        applyStimulus(1'b1, BLK_C, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("full_blocked_taken", {127'd0, dataTaken}, 128'd0);
        checkOutput("full_head_a", blkData, BLK_A);
        applyStimulus(1'b1, BLK_C, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, BLK_C, 1'b0);
        checkOutput("pop_a_count", {126'd0, blkCount}, 128'd1);
        checkOutput("pop_a_taken", {127'd0, dataTaken}, 128'd0);
        @(negedge clk);
        checkOutput("capture_c_taken", {127'd0, dataTaken}, 128'd1);
        checkOutput("capture_c_count", {126'd0, blkCount}, 128'd2);
        checkOutput("head_b", blkData, BLK_B);
        applyStimulus(1'b0, BLK_C, 1'b1);
        @(negedge clk);
        checkOutput("head_c", blkData, BLK_C);
        @(negedge clk);
        checkOutput("drained_count", {126'd0, blkCount}, 128'd0);
        applyStimulus(1'b0, BLK_C, 1'b0);
        @(negedge clk);

        // Streaming with the core always ready: pointers wrap several times
        streamMode = 1'b1;
        applyStimulus(1'b0, '0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            deliver({$urandom, $urandom, $urandom, $urandom});
        end
        @(negedge clk);
        checkOutput("stream_empty", {126'd0, blkCount}, 128'd0);
        streamMode = 1'b0;

        // Reset in the middle of a handshake with the FIFO full
        applyStimulus(1'b0, '0, 1'b0);
        deliver(BLK_A);
        applyStimulus(1'b1, BLK_B, 1'b0);
        @(negedge clk);
        checkOutput("midrst_pre_taken", {127'd0, dataTaken}, 128'd1);
        checkOutput("midrst_pre_count", {126'd0, blkCount}, 128'd2);
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("midrst_taken", {127'd0, dataTaken}, 128'd0);
        checkOutput("midrst_valid", {127'd0, blkValid}, 128'd0);
        checkOutput("midrst_count", {126'd0, blkCount}, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Randomized upstream following the 4-phase protocol, random core readiness
        for (int c = 0; c < 500; c++) begin
            if (!dataReady) begin
                if (!dataTaken && $urandom_range(0, 2) == 0) begin
                    dataReady = 1'b1;
                    blockIn   = {$urandom, $urandom, $urandom, $urandom};
                end
            end else if (dataTaken) begin
                dataReady = 1'b0;
            end
            blkReady = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 1) : 1'b0;
            @(negedge clk);
        end
        applyStimulus(1'b0, '0, 1'b1);
        repeat (6) @(negedge clk);
        checkOutput("final_empty", {126'd0, blkCount}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
